// File: rtl/cond_unit.sv
// ============================================================================
// Module  : cond_unit
// Purpose : ARM condition-check stage. Registers condition-gated PCSrc,
//           RegWrite and MemWrite requests and holds the architectural
//           NZCV flag register. Optional macro SKIP_CNT_EN adds a 16-bit
//           saturating count of consumed instructions that failed their
//           condition.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_in,
    input  logic       stall,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlag,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic       valid_out,
    output logic [3:0] Flags
`ifdef SKIP_CNT_EN
    ,
    output logic [15:0] skip_cnt
`endif
);

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;

    logic n_flag;
    logic z_flag;
    logic c_flag;
    logic v_flag;
    logic pass;
    logic consume;
    logic [3:0] flags_next;

    assign {n_flag, z_flag, c_flag, v_flag} = Flags;
    assign consume = valid_in & ~stall;

    // Evaluated against the stored flags so an instruction never sees its own update.
    always_comb begin
        pass = 1'b1;
        case (Cond)
            COND_EQ: pass = z_flag;
            COND_NE: pass = ~z_flag;
            COND_CS: pass = c_flag;
            COND_CC: pass = ~c_flag;
            COND_MI: pass = n_flag;
            COND_PL: pass = ~n_flag;
            COND_VS: pass = v_flag;
            COND_VC: pass = ~v_flag;
            COND_HI: pass = c_flag & ~z_flag;
            COND_LS: pass = ~c_flag | z_flag;
            COND_GE: pass = (n_flag == v_flag);
            COND_LT: pass = (n_flag != v_flag);
            COND_GT: pass = ~z_flag & (n_flag == v_flag);
            COND_LE: pass = z_flag | (n_flag != v_flag);
            default: pass = 1'b1;
        endcase
    end

    always_comb begin
        flags_next = Flags;
        if (consume && pass) begin
            if (FlagW[1]) begin
                flags_next[3:2] = ALUFlag[3:2];
            end
            if (FlagW[0]) begin
                flags_next[1:0] = ALUFlag[1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Flags     <= 4'b0000;
            PCSrc     <= 1'b0;
            RegWrite  <= 1'b0;
            MemWrite  <= 1'b0;
            CondEx    <= 1'b0;
            valid_out <= 1'b0;
        end else if (!stall) begin
            Flags     <= flags_next;
            CondEx    <= consume & pass;
            PCSrc     <= consume & pass & PCS;
            RegWrite  <= consume & pass & RegW;
            MemWrite  <= consume & pass & MemW;
            valid_out <= consume;
        end
    end

`ifdef SKIP_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            skip_cnt <= 16'h0000;
        end else if (consume && !pass && (skip_cnt != 16'hFFFF)) begin
            skip_cnt <= skip_cnt + 16'h0001;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cond_unit.sv
// ============================================================================
// Module  : tb_cond_unit
// Purpose : Directed and randomised checks of cond_unit against a flag-level
//           reference model, plus hand-computed literal expectations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cond_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_in;
    logic       stall;
    logic [3:0] Cond;
    logic [3:0] ALUFlag;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic       valid_out;
    logic [3:0] Flags;
`ifdef SKIP_CNT_EN
    logic [15:0] skip_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cond_unit dut (
        .clk      (clk),
        .reset    (reset),
        .valid_in (valid_in),
        .stall    (stall),
        .Cond     (Cond),
        .ALUFlag  (ALUFlag),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .RegW     (RegW),
        .MemW     (MemW),
        .PCSrc    (PCSrc),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .CondEx   (CondEx),
        .valid_out(valid_out),
        .Flags    (Flags)
`ifdef SKIP_CNT_EN
        ,
        .skip_cnt (skip_cnt)
`endif
    );

    // Conditions come in complementary pairs; odd codes invert the even one.
    function automatic logic exp_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: return 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic logic [3:0] exp_flags(input logic [3:0] f, input logic [3:0] alu,
                                             input logic [1:0] fw, input logic p);
        logic [3:0] r;
        r = f;
        if (p && fw[1]) r[3:2] = alu[3:2];
        if (p && fw[0]) r[1:0] = alu[1:0];
        return r;
    endfunction

    logic        m_valid = 1'b0;
    logic [3:0]  m_flags;
    logic        m_condex, m_pcsrc, m_regwrite, m_memwrite, m_vout;
    logic [15:0] m_skip;

    always @(posedge clk) begin
        if (reset) begin
            m_valid    <= 1'b1;
            m_flags    <= 4'h0;
            m_condex   <= 1'b0;
            m_pcsrc    <= 1'b0;
            m_regwrite <= 1'b0;
            m_memwrite <= 1'b0;
            m_vout     <= 1'b0;
            m_skip     <= 16'h0;
        end else if (!stall) begin
            if (valid_in) begin
                m_condex   <= exp_pass(Cond, m_flags);
                m_pcsrc    <= PCS  && exp_pass(Cond, m_flags);
                m_regwrite <= RegW && exp_pass(Cond, m_flags);
                m_memwrite <= MemW && exp_pass(Cond, m_flags);
                m_vout     <= 1'b1;
                m_flags    <= exp_flags(m_flags, ALUFlag, FlagW, exp_pass(Cond, m_flags));
                if (!exp_pass(Cond, m_flags) && m_skip != 16'hFFFF) m_skip <= m_skip + 16'h1;
            end else begin
                m_condex   <= 1'b0;
                m_pcsrc    <= 1'b0;
                m_regwrite <= 1'b0;
                m_memwrite <= 1'b0;
                m_vout     <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_flags",    {28'h0, Flags},     {28'h0, m_flags});
            check("model_condex",   {31'h0, CondEx},    {31'h0, m_condex});
            check("model_pcsrc",    {31'h0, PCSrc},     {31'h0, m_pcsrc});
            check("model_regwrite", {31'h0, RegWrite},  {31'h0, m_regwrite});
            check("model_memwrite", {31'h0, MemWrite},  {31'h0, m_memwrite});
            check("model_valid",    {31'h0, valid_out}, {31'h0, m_vout});
`ifdef SKIP_CNT_EN
            check("model_skip",     {16'h0, skip_cnt},  {16'h0, m_skip});
`endif
        end
    end

    task automatic set_in(input logic v, input logic s, input logic [3:0] c, input logic [3:0] a,
                          input logic [1:0] fw, input logic pcs, input logic rw, input logic mw);
        valid_in = v;
        stall    = s;
        Cond     = c;
        ALUFlag  = a;
        FlagW    = fw;
        PCS      = pcs;
        RegW     = rw;
        MemW     = mw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic consume(input logic [3:0] c, input logic [3:0] a, input logic [1:0] fw,
                           input logic pcs, input logic rw, input logic mw);
        set_in(1'b1, 1'b0, c, a, fw, pcs, rw, mw);
        tick();
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        // Reset with an instruction presented that must be discarded.
        reset = 1'b1;
        set_in(1'b1, 1'b0, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        check("reset_flags",    {28'h0, Flags},     32'h0);
        check("reset_valid",    {31'h0, valid_out}, 32'h0);
        check("reset_regwrite", {31'h0, RegWrite},  32'h0);
        reset = 1'b0;

        consume(4'b0000, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0);
        check("eq_fail_regwrite", {31'h0, RegWrite},  32'h0);
        check("eq_fail_condex",   {31'h0, CondEx},    32'h0);
        check("eq_fail_valid",    {31'h0, valid_out}, 32'h1);
        check("eq_fail_flags",    {28'h0, Flags},     32'h0);

        consume(4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0);
        check("al_set_z_flags", {28'h0, Flags}, 32'h4);
        consume(4'b0000, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1);
        check("eq_pass_memwrite", {31'h0, MemWrite}, 32'h1);
        check("eq_pass_condex",   {31'h0, CondEx},   32'h1);

        consume(4'b0001, 4'b1010, 2'b11, 1'b0, 1'b0, 1'b0);
        check("ne_fail_condex", {31'h0, CondEx}, 32'h0);
        check("ne_fail_flags",  {28'h0, Flags},  32'h4);

        consume(4'b1110, 4'b1001, 2'b11, 1'b0, 1'b0, 1'b0);
        consume(4'b1010, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        check("ge_condex", {31'h0, CondEx}, 32'h1);
        consume(4'b1100, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        check("gt_condex", {31'h0, CondEx}, 32'h1);
        consume(4'b1110, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b0);
        consume(4'b1011, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        check("lt_condex", {31'h0, CondEx}, 32'h1);

        // Partial flag writes from Flags=1000.
        consume(4'b1110, 4'b0111, 2'b01, 1'b0, 1'b0, 1'b0);
        check("flagw01_flags", {28'h0, Flags}, 32'hB);
        consume(4'b1110, 4'b0100, 2'b10, 1'b0, 1'b0, 1'b0);
        check("flagw10_flags", {28'h0, Flags}, 32'h7);

        consume(4'b1110, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0);
        check("pcs_pcsrc", {31'h0, PCSrc}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, 4'b1110, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0);
            tick();
            check("stall_pcsrc", {31'h0, PCSrc}, 32'h1);
            check("stall_flags", {28'h0, Flags}, 32'h7);
        end
        idle();
        check("post_stall_valid", {31'h0, valid_out}, 32'h0);
        check("post_stall_pcsrc", {31'h0, PCSrc},     32'h0);

        // Mid-stream reset must leave Z clear for the next consume.
        consume(4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        consume(4'b0000, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0);
        check("after_reset_eq_condex", {31'h0, CondEx}, 32'h0);
        consume(4'b1111, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0);
        check("cond1111_condex", {31'h0, CondEx},   32'h1);
        check("cond1111_regw",   {31'h0, RegWrite}, 32'h1);

        // Every condition code against every flag pattern.
        for (int f = 0; f < 16; f++) begin
            consume(4'b1110, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0);
            for (int c = 0; c < 16; c++) begin
                consume(4'(c), 4'($urandom), 2'b00, 1'($urandom), 1'($urandom), 1'($urandom));
            end
        end

        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), 4'($urandom),
                   4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            tick();
        end

`ifdef SKIP_CNT_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) consume(4'b0110, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        check("skip_cnt_five", {16'h0, skip_cnt}, 32'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("skip_cnt_reset", {16'h0, skip_cnt}, 32'd0);
`endif

        idle();
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 The block SHALL use a single clock; reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 valid_in  input  1  an instruction's control bits are presented this cycle.
REQ-005 stall  input  1  hold all state and outputs; the presented instruction is not consumed.
REQ-006 Cond  input  4  ARM condition field of the presented instruction.
REQ-007 ALUFlag  input  4  ALU flags of the presented instruction, packed {N,Z,C,V}.
REQ-008 FlagW  input  2  flag-write enables: [1] updates N,Z; [0] updates C,V.
REQ-009 PCS, RegW, MemW  input  1 each  unconditional branch, register-write and memory-write requests.
REQ-010 PCSrc, RegWrite, MemWrite  output  1 each  registered requests, gated by the condition.
REQ-011 CondEx  output  1  registered condition-pass result of the last consumed instruction.
REQ-012 valid_out  output  1  the registered outputs correspond to a consumed instruction.
REQ-013 Flags  output  4  current architectural flag register, {N,Z,C,V}.

Function
REQ-014 Consume SHALL be defined as valid_in=1 and stall=0, evaluated at the rising edge of clk.
REQ-015 pass SHALL be evaluated combinationally from the Flags register, not from ALUFlag, as follows:
- 0000 EQ Z; 0001 NE !Z
- 0010 CS C; 0011 CC !C
- 0100 MI N; 0101 PL !N
- 0110 VS V; 0111 VC !V
- 1000 HI C&!Z; 1001 LS !C|Z
- 1010 GE N==V; 1011 LT N!=V
- 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
- 1110 AL 1; 1111 SHALL evaluate to 1.
REQ-016 On consume, the block SHALL register:
- CondEx<=pass
- PCSrc<=PCS&pass
- RegWrite<=RegW&pass
- MemWrite<=MemW&pass
- valid_out<=1
REQ-017 The pipeline latency SHALL be one cycle from consume to the registered outputs.
REQ-018 When no consume occurs and stall=0, valid_out, PCSrc, RegWrite, MemWrite and CondEx SHALL all be registered to 0.
REQ-019 When stall=1, every register SHALL hold its value, independent of valid_in.
REQ-020 On consume with pass=1, the N,Z flag register bits SHALL load ALUFlag[3:2] if FlagW[1]=1, and the C,V bits SHALL load ALUFlag[1:0] if FlagW[0]=1.
REQ-021 On consume with pass=0, the flag register SHALL remain unchanged regardless of FlagW.
REQ-022 An instruction's own flag update SHALL NOT affect its own pass result; the updated flags SHALL be visible to the next consumed instruction.
REQ-023 FlagW=01 SHALL leave N and Z untouched, and FlagW=10 SHALL leave C and V untouched.

Reset
REQ-024 When reset=1 at a clock edge, the block SHALL clear Flags, PCSrc, RegWrite, MemWrite, CondEx and valid_out to 0, overriding stall and valid_in.
REQ-025 An instruction presented during the reset cycle SHALL be discarded and SHALL update no state.
REQ-026 When reset asserts mid-stream, the next consume after deassertion SHALL evaluate against Flags=0000.

Configuration
REQ-027 When SKIP_CNT_EN is defined, the block SHALL add the output skip_cnt (16 bits), defined as follows:
- increments on each consume with pass=0
- saturates at 16'hFFFF
- holds on stall
- clears on reset
REQ-028 When SKIP_CNT_EN is undefined, the skip_cnt port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 The bench SHALL cover the following scenario: reset, then consume Cond=0000 with RegW=1 -> after the next edge, RegWrite=0, CondEx=0, valid_out=1, Flags=0000.
REQ-030 The bench SHALL cover the following scenario: consume Cond=1110, FlagW=11, ALUFlag=0100 -> Flags=0100; then consume Cond=0000 with MemW=1 -> after the next edge, MemWrite=1, CondEx=1.
REQ-031 The bench SHALL cover the following scenario: with Flags=0100, consume Cond=0001 with FlagW=11, ALUFlag=1010 -> CondEx=0 and Flags stay 0100.
REQ-032 The bench SHALL cover the following scenario: with Flags=1001, consume Cond=1010 and then Cond=1100 -> both CondEx=1; with Flags=1000, Cond=1011 -> CondEx=1.
REQ-033 The bench SHALL cover the following scenario: consume PCS=1, Cond=1110, then hold stall=1 for 3 cycles with valid_in=1 -> PCSrc stays 1 and Flags are unchanged; after stall drops with valid_in=0 -> valid_out=0.
REQ-034 The bench SHALL cover the following scenario (only when SKIP_CNT_EN is defined): 5 consumes with failing Cond=0110 at Flags=0000 -> skip_cnt=5; then assert reset -> skip_cnt=0.
